// File: rtl/calc_stream_ctrl.sv
// calc_stream_ctrl: streams operand words from memory through a mode-selected ALU and writes back two results per word
module calc_stream_ctrl #(
  parameter int ADDR_W        = 10,
  parameter int DATA_W        = 32,
  parameter int MEM_WORD_SIZE = 64,
  parameter int RD_LAT        = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [1:0]               mode_i,
  input  logic [ADDR_W-1:0]        read_start_addr,
  input  logic [ADDR_W-1:0]        read_end_addr,
  input  logic [ADDR_W-1:0]        write_start_addr,
  input  logic [ADDR_W-1:0]        write_end_addr,
  output logic                     read,
  output logic [ADDR_W-1:0]        r_addr,
  input  logic [MEM_WORD_SIZE-1:0] r_data,
  output logic                     write,
  output logic [ADDR_W-1:0]        w_addr,
  output logic [MEM_WORD_SIZE-1:0] w_data,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [ADDR_W:0]          words_written_o
);
  if (MEM_WORD_SIZE != 2*DATA_W || RD_LAT < 1 || RD_LAT > 4) begin : g_bad_cfg
    $error("calc_stream_ctrl: illegal parameter combination");
  end
  typedef enum logic [2:0] {IDLE, CHECK, RD, WAIT, EXEC, WR, DONE} state_t;
  state_t state, nxt;
  logic [1:0]               mode, cnt;
  logic [ADDR_W-1:0]        rs, re, ws, we, rptr, wptr;
  logic                     hi, last, bad;
  logic [MEM_WORD_SIZE-1:0] op, pack;
  logic [ADDR_W:0]          n, w;
  logic [ADDR_W-1:0]        half;
  logic [DATA_W-1:0]        a, b, dif, res;
  logic [DATA_W:0]          sum;
  always_comb begin
    n    = {1'b0, re} - {1'b0, rs} + (ADDR_W+1)'(1);
    w    = {1'b0, we} - {1'b0, ws} + (ADDR_W+1)'(1);
    half = n[ADDR_W:1] + ADDR_W'(n[0]);
    bad  = re < rs || we < ws || w != {1'b0, half};
    last = rptr == re;
    a    = op[DATA_W-1:0];
    b    = op[MEM_WORD_SIZE-1:DATA_W];
    sum  = {1'b0, a} + {1'b0, b};
    dif  = a - b;
    res  = mode == 2'd0 ? sum[DATA_W-1:0] :
           mode == 2'd1 ? dif :
           mode == 2'd2 ? (sum[DATA_W] ? '1 : sum[DATA_W-1:0]) :
                          (b > a ? '0 : dif);
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start_i ? CHECK : IDLE;
      CHECK:   nxt = bad ? DONE : RD;
      RD:      nxt = WAIT;
      WAIT:    nxt = cnt == 2'(RD_LAT-1) ? EXEC : WAIT;
      EXEC:    nxt = hi || last ? WR : RD;
      WR:      nxt = last ? DONE : RD;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      mode            <= '0;
      cnt             <= '0;
      rs              <= '0;
      re              <= '0;
      ws              <= '0;
      we              <= '0;
      rptr            <= '0;
      wptr            <= '0;
      hi              <= 1'b0;
      op              <= '0;
      pack            <= '0;
      err_o           <= 1'b0;
      words_written_o <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          mode            <= mode_i;
          rs              <= read_start_addr;
          re              <= read_end_addr;
          ws              <= write_start_addr;
          we              <= write_end_addr;
          rptr            <= read_start_addr;
          wptr            <= write_start_addr;
          hi              <= 1'b0;
          pack            <= '0;
          err_o           <= 1'b0;
          words_written_o <= '0;
        end
        CHECK: err_o <= bad;
        RD: cnt <= '0;
        WAIT: begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'(RD_LAT-1)) op <= r_data;
        end
        EXEC: begin
          if (hi) pack[MEM_WORD_SIZE-1:DATA_W] <= res;
          else pack[DATA_W-1:0] <= res;
          if (!hi && !last) begin
            rptr <= rptr + ADDR_W'(1);
            hi   <= 1'b1;
          end
        end
        WR: begin
          pack            <= '0;
          hi              <= 1'b0;
          words_written_o <= words_written_o + (ADDR_W+1)'(1);
          if (!last) begin
            rptr <= rptr + ADDR_W'(1);
            wptr <= wptr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  assign read   = state == RD;
  assign write  = state == WR;
  assign r_addr = rptr;
  assign w_addr = wptr;
  assign w_data = pack;
  assign busy_o = state != IDLE;
  assign done_o = state == DONE;
endmodule

// File: tb/tb_calc_stream_ctrl.sv
// tb_calc_stream_ctrl: scoreboard bench for calc_stream_ctrl at read latencies 1 and 3
module tb_calc_stream_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, start, sel;
  logic [1:0] mode;
  logic [9:0] rs, re, ws, we;
  logic rd1, wr1, busy1, done1, err1, rd3, wr3, busy3, done3, err3;
  logic [9:0] ra1, wa1, ra3, wa3;
  logic [63:0] rdat1, wdat1, rdat3, wdat3;
  logic [10:0] ww1, ww3;
  logic start1, start3;
  assign start1 = start & ~sel;
  assign start3 = start & sel;
  calc_stream_ctrl #(.RD_LAT(1)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .mode_i(mode),
    .read_start_addr(rs), .read_end_addr(re), .write_start_addr(ws), .write_end_addr(we),
    .read(rd1), .r_addr(ra1), .r_data(rdat1), .write(wr1), .w_addr(wa1), .w_data(wdat1),
    .busy_o(busy1), .done_o(done1), .err_o(err1), .words_written_o(ww1)
  );
  calc_stream_ctrl #(.RD_LAT(3)) u3 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start3), .mode_i(mode),
    .read_start_addr(rs), .read_end_addr(re), .write_start_addr(ws), .write_end_addr(we),
    .read(rd3), .r_addr(ra3), .r_data(rdat3), .write(wr3), .w_addr(wa3), .w_data(wdat3),
    .busy_o(busy3), .done_o(done3), .err_o(err3), .words_written_o(ww3)
  );
  logic rd_s, wr_s, busy_s, done_s, err_s;
  logic [9:0] ra_s, wa_s;
  logic [63:0] wd_s;
  logic [10:0] ww_s;
  assign rd_s   = sel ? rd3 : rd1;
  assign wr_s   = sel ? wr3 : wr1;
  assign busy_s = sel ? busy3 : busy1;
  assign done_s = sel ? done3 : done1;
  assign err_s  = sel ? err3 : err1;
  assign ra_s   = sel ? ra3 : ra1;
  assign wa_s   = sel ? wa3 : wa1;
  assign wd_s   = sel ? wdat3 : wdat1;
  assign ww_s   = sel ? ww3 : ww1;
  logic [63:0] mem [0:1023];
  logic ld;
  logic [9:0] ld_a;
  logic [63:0] ld_d;
  logic [63:0] p1_d;
  logic p1_v;
  logic [63:0] p3_d [3];
  logic [2:0] p3_v;
  always @(posedge clk) begin
    if (ld) mem[ld_a] <= ld_d;
    if (wr1) mem[wa1] <= wdat1;
    if (wr3) mem[wa3] <= wdat3;
    p1_d    <= mem[ra1];
    p1_v    <= rd1;
    p3_d[0] <= mem[ra3];
    p3_d[1] <= p3_d[0];
    p3_d[2] <= p3_d[1];
    p3_v    <= {p3_v[1:0], rd3};
  end
  assign rdat1 = p1_v ? p1_d : 64'hDEADBEEF_BADC0FFE;
  assign rdat3 = p3_v[2] ? p3_d[2] : 64'hDEADBEEF_BADC0FFE;
  typedef struct {logic [9:0] a; logic [63:0] d;} wr_t;
  wr_t q[$];
  int total = 0;
  int bad = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] alu(input logic [1:0] m, input logic [63:0] wd);
    logic [31:0] x, y;
    logic [32:0] s;
    x = wd[31:0];
    y = wd[63:32];
    s = {1'b0, x} + {1'b0, y};
    case (m)
      2'd0: return x + y;
      2'd1: return x - y;
      2'd2: return s > 33'h0FFFFFFFF ? 32'hFFFFFFFF : s[31:0];
      default: return y > x ? 32'd0 : x - y;
    endcase
  endfunction
  task automatic load(input logic [9:0] a, input logic [63:0] d);
    ld = 1'b1;
    ld_a = a;
    ld_d = d;
    @(negedge clk);
    ld = 1'b0;
  endtask
  task automatic run(input logic s, input logic [1:0] m, input logic [9:0] a0, input logic [9:0] a1,
                     input logic [9:0] b0, input logic [9:0] b1, input int abort);
    int n, lat, cyc, nrd, exp_cyc;
    logic e;
    wr_t x;
    sel = s; mode = m; rs = a0; re = a1; ws = b0; we = b1;
    lat = s ? 3 : 1;
    n = int'(a1) - int'(a0) + 1;
    e = a1 < a0 || b1 < b0 || (int'(b1) - int'(b0) + 1) != (n + 1) / 2;
    q.delete();
    if (!e)
      for (int i = 0; i < n; i += 2) begin
        x.a = 10'(int'(b0) + i / 2);
        x.d = {i + 1 < n ? alu(m, mem[10'(int'(a0) + i + 1)]) : 32'd0, alu(m, mem[10'(int'(a0) + i)])};
        q.push_back(x);
      end
    exp_cyc = e ? 2 : 1 + n * (2 + lat) + (n + 1) / 2 + 1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    nrd = 0;
    chk("busy_run", 64'(busy_s), 64'd1);
    while (!done_s && cyc < 200) begin
      if (rd_s) begin
        chk("r_addr", 64'(ra_s), 64'(int'(a0) + nrd));
        nrd++;
      end
      if (wr_s) begin
        if (q.size() == 0) chk("w_extra", 64'(wr_s), 64'd0);
        else begin
          x = q.pop_front();
          chk("w_addr", 64'(wa_s), 64'(x.a));
          chk("w_data", wd_s, x.d);
        end
      end
      if (cyc == abort) begin
        rst_n = 1'b0;
        #1;
        chk("rst_ctl", 64'({rd_s, wr_s, busy_s, done_s, err_s, ww_s, ra_s, wa_s}), 64'd0);
        chk("rst_wdata", wd_s, 64'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      start = cyc == 3 && !e;
      @(negedge clk);
      cyc++;
    end
    start = 1'b1;
    chk("done_cyc", 64'(cyc), 64'(exp_cyc));
    chk("err", 64'(err_s), 64'(e));
    chk("words_written", 64'(ww_s), e ? 64'd0 : 64'((n + 1) / 2));
    chk("n_reads", 64'(nrd), e ? 64'd0 : 64'(n));
    chk("q_left", 64'(q.size()), 64'd0);
    @(negedge clk);
    start = 1'b0;
    chk("idle_after", 64'({busy_s, done_s}), 64'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    rst_n = 1'b0; start = 1'b0; sel = 1'b0; mode = '0;
    rs = '0; re = '0; ws = '0; we = '0; ld = 1'b0; ld_a = '0; ld_d = '0;
    repeat (2) @(negedge clk);
    chk("rst1", 64'({rd1, wr1, busy1, done1, err1, ww1}), 64'd0);
    chk("rst3", 64'({rd3, wr3, busy3, done3, err3, ww3}), 64'd0);
    chk("rst_wdata1", wdat1, 64'd0);
    rst_n = 1'b1;
    load(0, {32'd2, 32'd1}); load(1, {32'd4, 32'd3}); load(2, {32'd6, 32'd5}); load(3, {32'd8, 32'd7});
    run(0, 2'd0, 0, 3, 10, 11, 0);
    chk("mem10", mem[10], 64'h00000007_00000003);
    chk("mem11", mem[11], 64'h0000000F_0000000B);
    load(20, {32'd9, 32'd5}); load(21, {32'd5, 32'd9});
    run(0, 2'd3, 20, 21, 30, 30, 0);
    chk("mem30", mem[30], 64'h00000004_00000000);
    load(22, {32'd2, 32'hFFFFFFFF});
    run(0, 2'd2, 22, 22, 31, 31, 0);
    chk("mem31", mem[31], 64'h00000000_FFFFFFFF);
    load(40, {32'd3, 32'd10}); load(41, {32'd8, 32'd8}); load(42, {32'd0, 32'd1});
    run(0, 2'd1, 40, 42, 50, 51, 0);
    chk("mem50", mem[50], 64'h00000000_00000007);
    chk("mem51", mem[51], 64'h00000000_00000001);
    run(0, 2'd0, 0, 3, 0, 0, 0);
    chk("mem0_kept", mem[0], 64'h00000002_00000001);
    run(0, 2'd0, 5, 4, 0, 0, 0);
    run(0, 2'd0, 0, 1, 5, 4, 0);
    load(1022, {32'd1, 32'd10}); load(1023, {32'd20, 32'd5});
    run(0, 2'd1, 1022, 1023, 1023, 1023, 0);
    chk("mem1023", mem[1023], 64'hFFFFFFF1_00000009);
    load(60, {32'd4, 32'd5}); load(61, {32'd6, 32'd7});
    run(1, 2'd0, 60, 61, 70, 70, 0);
    chk("mem70", mem[70], 64'h0000000D_00000009);
    load(80, {32'd1, 32'd2}); load(81, {32'hFFFFFFFF, 32'd1});
    run(1, 2'd2, 80, 81, 90, 90, 0);
    chk("mem90", mem[90], 64'hFFFFFFFF_00000003);
    run(0, 2'd0, 0, 3, 12, 13, 6);
    run(0, 2'd0, 0, 3, 14, 15, 0);
    chk("mem14", mem[14], 64'h00000007_00000003);
    chk("mem15", mem[15], 64'h0000000F_0000000B);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
